// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type and sizing helpers for the SPI master
package spi_pkg;

  localparam int CLK_DIV_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } spi_state_e;

  function automatic int frame_bits(input int data_byte_width);
    return 8 + data_byte_width * 8;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period counter producing the mode-0 sCLK level and edge ticks
// Ticks are asserted in the cycle before the sCLK level changes, so the FSM can act on the same edge.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic en,
  input  logic toggle_en,
  output logic sclk,
  output logic half_tick,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [CLK_DIV_W-1:0] DIV_LAST = CLK_DIV_W'(CLK_DIV - 1);

  logic [CLK_DIV_W-1:0] cnt_q, cnt_d;
  logic                 sclk_q, sclk_d;

  assign half_tick = en && (cnt_q == DIV_LAST);
  assign rise_tick = half_tick && toggle_en && !sclk_q;
  assign fall_tick = half_tick && toggle_en && sclk_q;
  assign sclk      = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (half_tick) begin
      cnt_d = '0;
      if (toggle_en) begin
        sclk_d = !sclk_q;
      end
    end else begin
      cnt_d = cnt_q + CLK_DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - mode-0 SPI master sending a command byte plus data bytes per frame
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_BYTE_WIDTH = 1,
  parameter int CLK_DIV         = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         start,
  input  logic [DATA_BYTE_WIDTH*8+7:0] master_tx_data,
  output logic                         busy,
  output logic                         sCLK,
  output logic                         CS,
  output logic                         MOSI,
  input  logic                         MISO,
  output logic                         load_en,
  output logic [DATA_BYTE_WIDTH*8-1:0] master_rx_data,
  output logic                         rx_reg
);

  localparam int FRAME_BITS = frame_bits(DATA_BYTE_WIDTH);
  localparam int RX_W       = DATA_BYTE_WIDTH * 8;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  spi_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [RX_W-1:0]       rx_shift_q, rx_shift_d;
  logic [RX_W-1:0]       rx_data_q, rx_data_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_q, cs_d;
  logic                  load_en_q, load_en_d;
  logic                  busy_q, busy_d;
  logic                  rx_reg_q, rx_reg_d;
  logic                  sample_q, sample_d;

  logic gen_en, toggle_en, half_tick, rise_tick, fall_tick;

  assign gen_en    = (state_q == LEAD) || (state_q == SHIFT) || (state_q == TRAIL);
  assign toggle_en = (state_q != TRAIL);

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .en       (gen_en),
    .toggle_en(toggle_en),
    .sclk     (sCLK),
    .half_tick(half_tick),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    mosi_d     = mosi_q;
    cs_d       = cs_q;
    load_en_d  = load_en_q;
    busy_d     = busy_q;
    rx_reg_d   = 1'b0;
    // rise_tick precedes the high sCLK cycle; MISO is captured at the end of that cycle
    sample_d   = rise_tick;

    if (sample_q) begin
      rx_shift_d = {rx_shift_q[RX_W-2:0], MISO};
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_shift_d = master_tx_data;
          mosi_d     = master_tx_data[FRAME_BITS-1];
          bit_cnt_d  = CNT_W'(FRAME_BITS);
          cs_d       = 1'b0;
          load_en_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = LEAD;
        end
      end
      LEAD: begin
        if (rise_tick) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
          mosi_d     = tx_shift_q[FRAME_BITS-2];
          bit_cnt_d  = bit_cnt_q - CNT_W'(1);
          if (bit_cnt_q == CNT_W'(1)) begin
            state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (half_tick) begin
          cs_d      = 1'b1;
          load_en_d = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_shift_q;
          rx_reg_d  = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
      load_en_q  <= 1'b1;
      busy_q     <= 1'b0;
      rx_reg_q   <= 1'b0;
      sample_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
      load_en_q  <= load_en_d;
      busy_q     <= busy_d;
      rx_reg_q   <= rx_reg_d;
      sample_q   <= sample_d;
    end
  end

  assign MOSI           = mosi_q;
  assign CS             = cs_q;
  assign load_en        = load_en_q;
  assign busy           = busy_q;
  assign rx_reg         = rx_reg_q;
  assign master_rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst;
  logic        start_a, busy_a, sclk_a, cs_a, mosi_a, miso_a, load_en_a, rx_reg_a;
  logic [15:0] tx_a;
  logic [7:0]  rxd_a;
  logic        loop_a, miso_val_a;
  logic        start_b, busy_b, sclk_b, cs_b, mosi_b, miso_b, load_en_b, rx_reg_b;
  logic [23:0] tx_b;
  logic [15:0] rxd_b;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [4:0] vec_tr [0:199];
  logic       mosi_tr[0:199];
  logic [7:0] rxd_tr [0:199];

  assign miso_a = loop_a ? mosi_a : miso_val_a;

  spi_master_ctrl #(.DATA_BYTE_WIDTH(1), .CLK_DIV(2)) dut_a (
    .i_clk(clk), .i_rst(i_rst), .start(start_a), .master_tx_data(tx_a), .busy(busy_a),
    .sCLK(sclk_a), .CS(cs_a), .MOSI(mosi_a), .MISO(miso_a), .load_en(load_en_a),
    .master_rx_data(rxd_a), .rx_reg(rx_reg_a));

  spi_master_ctrl #(.DATA_BYTE_WIDTH(2), .CLK_DIV(1)) dut_b (
    .i_clk(clk), .i_rst(i_rst), .start(start_b), .master_tx_data(tx_b), .busy(busy_b),
    .sCLK(sclk_b), .CS(cs_b), .MOSI(mosi_b), .MISO(miso_b), .load_en(load_en_b),
    .master_rx_data(rxd_b), .rx_reg(rx_reg_b));

  // sCLK is high during odd half-periods after the LEAD phase, for 2*fb half-periods
  function automatic logic exp_sclk(input int r, input int cd, input int fb);
    int h;
    if (r < 1) return 1'b0;
    h = (r - 1) / cd;
    return ((h % 2) == 1 && h <= 2 * fb - 1) ? 1'b1 : 1'b0;
  endfunction

  // {CS, busy, sCLK, rx_reg, load_en} at cycle r after the accepted start
  function automatic logic [4:0] exp_vec(input int r, input int cd, input int fb);
    int done_c;
    done_c = 1 + cd * (2 * fb + 1);
    if (r < 1 || r > done_c) return 5'b10001;
    if (r == done_c) return 5'b11011;
    return {1'b0, 1'b1, exp_sclk(r, cd, fb), 2'b00};
  endfunction

  logic pcs_a, psclk_a, pmosi_a, pcs_b, psclk_b, pmosi_b;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (load_en_a !== cs_a) begin
        errors++;
        $display("FAIL mon_load_en_a: load_en=%b CS=%b, required equal", load_en_a, cs_a);
      end
      checks++;
      if (cs_a === 1'b0 && ($isunknown(mosi_a) ||
          (pcs_a === 1'b0 && mosi_a !== pmosi_a && !(psclk_a === 1'b1 && sclk_a === 1'b0)))) begin
        errors++;
        $display("FAIL mon_mosi_a: MOSI %b->%b with sCLK %b->%b, required change only on falling sCLK",
                 pmosi_a, mosi_a, psclk_a, sclk_a);
      end
      checks++;
      if (load_en_b !== cs_b) begin
        errors++;
        $display("FAIL mon_load_en_b: load_en=%b CS=%b, required equal", load_en_b, cs_b);
      end
      checks++;
      if (cs_b === 1'b0 && ($isunknown(mosi_b) ||
          (pcs_b === 1'b0 && mosi_b !== pmosi_b && !(psclk_b === 1'b1 && sclk_b === 1'b0)))) begin
        errors++;
        $display("FAIL mon_mosi_b: MOSI %b->%b with sCLK %b->%b, required change only on falling sCLK",
                 pmosi_b, mosi_b, psclk_b, sclk_b);
      end
    end
    pcs_a = cs_a; psclk_a = sclk_a; pmosi_a = mosi_a;
    pcs_b = cs_b; psclk_b = sclk_b; pmosi_b = mosi_b;
  end

  // Drives DUT A for ncyc cycles (start at cycle 0 and at sa/sb/sc) and records its outputs
  task automatic capture_a(input logic [15:0] tx, input logic [15:0] tx2, input int tx2_at,
                           input int sa, input int sb, input int sc, input int rst_at, input int ncyc);
    tx_a = tx;
    @(posedge clk); #1;
    for (int n = 0; n < ncyc; n++) begin
      start_a = (n == 0) || (n == sa) || (n == sb) || (n == sc);
      i_rst   = (n == rst_at);
      if (n == tx2_at) tx_a = tx2;
      @(negedge clk);
      vec_tr[n]  = {cs_a, busy_a, sclk_a, rx_reg_a, load_en_a};
      mosi_tr[n] = mosi_a;
      rxd_tr[n]  = rxd_a;
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    i_rst   = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
    tx_a = 16'hFFFF; tx_b = 24'hFFFFFF; loop_a = 1'b0; miso_val_a = 1'b0; miso_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({cs_a, sclk_a, mosi_a, load_en_a, busy_a, rx_reg_a} !== 6'b100100) begin
      errors++;
      $display("FAIL reset_a_outputs: got %b, required 100100",
               {cs_a, sclk_a, mosi_a, load_en_a, busy_a, rx_reg_a});
    end
    checks++;
    if (rxd_a !== 8'h00) begin errors++; $display("FAIL reset_a_rxdata: got %h, required 00", rxd_a); end
    checks++;
    if ({cs_b, sclk_b, mosi_b, load_en_b, busy_b, rx_reg_b} !== 6'b100100) begin
      errors++;
      $display("FAIL reset_b_outputs: got %b, required 100100",
               {cs_b, sclk_b, mosi_b, load_en_b, busy_b, rx_reg_b});
    end
    checks++;
    if (rxd_b !== 16'h0000) begin errors++; $display("FAIL reset_b_rxdata: got %h, required 0000", rxd_b); end
    @(posedge clk); #1;
    i_rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_a, cs_a, busy_b, cs_b} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_start_ignored: busy/CS got %b, required 0101", {busy_a, cs_a, busy_b, cs_b});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_frame_loop();
    logic [15:0] tx;
    tx = 16'hA55A;
    loop_a = 1'b1;
    capture_a(tx, 16'h0000, -1, -1, -1, -1, -1, 72);
    for (int n = 0; n < 72; n++) begin
      checks++;
      if (vec_tr[n] !== exp_vec(n, 2, 16)) begin
        errors++;
        $display("FAIL frame_loop_vec cycle %0d: got %b, required %b", n, vec_tr[n], exp_vec(n, 2, 16));
      end
    end
    for (int n = 1; n < 65; n++) begin
      checks++;
      if (mosi_tr[n] !== tx[15 - (n - 1) / 4]) begin
        errors++;
        $display("FAIL frame_loop_mosi cycle %0d: got %b, required %b", n, mosi_tr[n], tx[15 - (n - 1) / 4]);
      end
    end
    checks++;
    if (rxd_tr[71] !== 8'h5A) begin
      errors++;
      $display("FAIL frame_loop_rxdata: got %h, required 5A", rxd_tr[71]);
    end
  endtask

  task automatic test_miso_ones();
    int rises, pulses;
    loop_a = 1'b0; miso_val_a = 1'b1;
    capture_a(16'h0000, 16'h0000, -1, -1, -1, -1, -1, 72);
    rises = 0; pulses = 0;
    for (int n = 0; n < 72; n++) begin
      if (n > 0 && vec_tr[n][2] === 1'b1 && vec_tr[n-1][2] === 1'b0) rises++;
      if (vec_tr[n][1] === 1'b1) pulses++;
      checks++;
      if (mosi_tr[n] !== 1'b0) begin
        errors++;
        $display("FAIL miso_ones_mosi cycle %0d: got %b, required 0", n, mosi_tr[n]);
      end
    end
    checks++;
    if (rises != 16) begin errors++; $display("FAIL miso_ones_rises: got %0d, required 16", rises); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL miso_ones_rx_reg: got %0d pulses, required 1", pulses); end
    checks++;
    if (rxd_tr[71] !== 8'hFF) begin errors++; $display("FAIL miso_ones_rxdata: got %h, required FF", rxd_tr[71]); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    loop_a = 1'b1;
    capture_a(16'hA55A, 16'h3CC3, 40, 10, 67, 68, -1, 140);
    for (int n = 0; n < 140; n++) begin
      e = (n <= 67) ? exp_vec(n, 2, 16) : exp_vec(n - 68, 2, 16);
      checks++;
      if (vec_tr[n] !== e) begin
        errors++;
        $display("FAIL back_to_back_vec cycle %0d: got %b, required %b", n, vec_tr[n], e);
      end
    end
    checks++;
    if (rxd_tr[66] !== 8'hFF) begin errors++; $display("FAIL b2b_hold_before: got %h, required FF", rxd_tr[66]); end
    checks++;
    if (rxd_tr[100] !== 8'h5A) begin errors++; $display("FAIL b2b_first_rx: got %h, required 5A", rxd_tr[100]); end
    checks++;
    if (rxd_tr[139] !== 8'hC3) begin errors++; $display("FAIL b2b_second_rx: got %h, required C3", rxd_tr[139]); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] e;
    loop_a = 1'b1;
    capture_a(16'hA55A, 16'h0000, -1, -1, -1, -1, 30, 80);
    for (int n = 0; n < 80; n++) begin
      e = (n <= 30) ? exp_vec(n, 2, 16) : 5'b10001;
      checks++;
      if (vec_tr[n] !== e) begin
        errors++;
        $display("FAIL reset_mid_vec cycle %0d: got %b, required %b", n, vec_tr[n], e);
      end
    end
    checks++;
    if (rxd_tr[30] !== 8'hC3) begin errors++; $display("FAIL reset_mid_hold: got %h, required C3", rxd_tr[30]); end
    checks++;
    if (rxd_tr[31] !== 8'h00 || rxd_tr[79] !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_rxdata: got %h/%h, required 00/00", rxd_tr[31], rxd_tr[79]);
    end
    checks++;
    if (mosi_tr[31] !== 1'b0) begin errors++; $display("FAIL reset_mid_mosi: got %b, required 0", mosi_tr[31]); end
  endtask

  task automatic test_clkdiv1();
    logic [23:0] tx, pat;
    logic [4:0]  v;
    tx = 24'h9F1234; pat = 24'h00BEEF;
    tx_b = tx;
    @(posedge clk); #1;
    for (int n = 0; n < 55; n++) begin
      start_b = (n == 0);
      miso_b  = (n >= 1 && (n - 1) / 2 < 24) ? pat[23 - (n - 1) / 2] : 1'b0;
      @(negedge clk);
      v = {cs_b, busy_b, sclk_b, rx_reg_b, load_en_b};
      checks++;
      if (v !== exp_vec(n, 1, 24)) begin
        errors++;
        $display("FAIL clkdiv1_vec cycle %0d: got %b, required %b", n, v, exp_vec(n, 1, 24));
      end
      if (n >= 1 && n < 49) begin
        checks++;
        if (mosi_b !== tx[23 - (n - 1) / 2]) begin
          errors++;
          $display("FAIL clkdiv1_mosi cycle %0d: got %b, required %b", n, mosi_b, tx[23 - (n - 1) / 2]);
        end
      end
      @(posedge clk); #1;
    end
    start_b = 1'b0; miso_b = 1'b0;
    checks++;
    if (rxd_b !== 16'hBEEF) begin errors++; $display("FAIL clkdiv1_rxdata: got %h, required BEEF", rxd_b); end
  endtask

  initial begin
    test_reset();
    test_frame_loop();
    test_miso_ones();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_BYTE_WIDTH, default 1, giving the number of data bytes per frame.
REQ-002 The block SHALL have parameter CLK_DIV, default 2, giving the sCLK half-period in i_clk cycles (legal range 1..255).
REQ-003 The block SHALL have port i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  frame request, sampled only while busy=0.
REQ-006 The block SHALL have port master_tx_data  input  DATA_BYTE_WIDTH*8+8  command byte in the top 8 bits, followed by the data bytes; sent MSB first.
REQ-007 The block SHALL have port busy  output  1  frame in progress.
REQ-008 The block SHALL have port sCLK  output  1  SPI clock, mode 0 (idle low).
REQ-009 The block SHALL have port CS  output  1  chip select, active-low.
REQ-010 The block SHALL have port MOSI  output  1  serial data out.
REQ-011 The block SHALL have port MISO  input  1  serial data in.
REQ-012 The block SHALL have port load_en  output  1  high while idle (tx register loadable); low for the whole frame.
REQ-013 The block SHALL have port master_rx_data  output  DATA_BYTE_WIDTH*8  last DATA_BYTE_WIDTH*8 bits received on MISO.
REQ-014 The block SHALL have port rx_reg  output  1  one-cycle pulse, asserted in the cycle master_rx_data takes a new value.

Function
REQ-015 FRAME_BITS SHALL equal 8+DATA_BYTE_WIDTH*8.
REQ-016 The FSM SHALL have states IDLE, LEAD, SHIFT, TRAIL and DONE.
REQ-017 In IDLE, start=1 at cycle 0 SHALL latch master_tx_data into the shift register and move to LEAD; from cycle 1, CS=0, load_en=0, busy=1 and MOSI=bit FRAME_BITS-1.
REQ-018 LEAD SHALL last CLK_DIV cycles; SHIFT SHALL toggle sCLK every CLK_DIV cycles, for 2*FRAME_BITS toggles.
REQ-019 Bit k (k=0 is the MSB) SHALL have its sCLK rising edge at cycle 1+CLK_DIV*(2k+1), and its falling edge at cycle 1+CLK_DIV*(2k+2).
REQ-020 MISO SHALL be sampled into the rx shift register in the i_clk cycle in which sCLK rises.
REQ-021 MOSI SHALL change only in the cycle in which sCLK falls (except for the first bit, per REQ-017), and SHALL never be X while CS=0.
REQ-022 After the last falling edge, TRAIL SHALL hold sCLK=0 and CS=0 for CLK_DIV cycles.
REQ-023 In DONE, at cycle 1+CLK_DIV*(2*FRAME_BITS+1), the block SHALL drive CS=1 and load_en=1, update master_rx_data and drive rx_reg=1; the FSM then SHALL return to IDLE and busy SHALL deassert in the next cycle.
REQ-024 start SHALL be ignored while busy=1; a start in the first cycle with busy=0 SHALL be accepted, so back-to-back frames are possible.
REQ-025 master_rx_data SHALL hold its value between frames; rx_reg SHALL pulse exactly once per completed frame.
REQ-026 With CLK_DIV=1, sCLK SHALL toggle every cycle and the timing of REQ-019 to REQ-023 SHALL still hold.
REQ-027 In IDLE, MOSI SHALL be 0 and sCLK SHALL be 0.

Reset
REQ-028 With i_rst=1 on a clock edge, the outputs SHALL become CS=1, sCLK=0, MOSI=0, load_en=1, busy=0, rx_reg=0 and master_rx_data=0, and the FSM SHALL enter IDLE.
REQ-029 A reset mid-frame SHALL abort the frame, SHALL produce no rx_reg pulse, and SHALL leave master_rx_data at 0.
REQ-030 The block SHALL ignore start in the cycle in which i_rst=1.

Structure
REQ-031 Package spi_pkg SHALL hold the state enum, the FRAME_BITS function and the CLK_DIV width constant.
REQ-032 Sub-module spi_sclk_gen SHALL hold the half-period counter, and SHALL produce one-cycle rise_tick and fall_tick plus the sCLK level, enabled by the FSM.
REQ-033 The bit counter SHALL be $clog2(FRAME_BITS+1) wide, and SHALL count down from FRAME_BITS to 0 without wrap.

Verification
REQ-034 DATA_BYTE_WIDTH=1 and CLK_DIV=2, tx=16'hA55A, with MISO looped to MOSI -> CS low for cycles 1..66, rx_reg at cycle 67, master_rx_data=8'h5A.
REQ-035 MISO tied to 1 and tx=16'h0000 -> MOSI stays 0, master_rx_data=8'hFF, 16 sCLK rising edges counted.
REQ-036 start pulsed at cycles 0, 10 and 67 -> the cycle-10 start is ignored, the cycle-67 start is ignored (busy=1), and a start at cycle 68 begins a second frame at cycle 69.
REQ-037 i_rst=1 at cycle 30 of a frame -> at cycle 31 CS=1, sCLK=0 and busy=0; no rx_reg pulse; master_rx_data=0.
REQ-038 CLK_DIV=1 and DATA_BYTE_WIDTH=2, tx=24'h9F_1234, with MISO fed 16'hBEEF in the data phase -> rx_reg at cycle 50, master_rx_data=16'hBEEF.
REQ-039 A checker in every test SHALL confirm that MOSI changes only on falling sCLK while CS=0, and that load_en falls in the same cycle as CS.
